// File: rtl/axis_pkg.sv
//------------------------------------------------------------------------------
// axis_pkg : shared AXI-Stream widths and frame-transmitter state encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_LEN_WIDTH  = 16;
    localparam int AXIS_CNT_WIDTH  = 8;

    localparam int TX_STATE_WIDTH = 2;
    localparam logic [TX_STATE_WIDTH-1:0] ST_IDLE = 2'd0;
    localparam logic [TX_STATE_WIDTH-1:0] ST_SEND = 2'd1;
    localparam logic [TX_STATE_WIDTH-1:0] ST_GAP  = 2'd2;
    localparam logic [TX_STATE_WIDTH-1:0] ST_FIN  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/axis_frame_tx.sv
//------------------------------------------------------------------------------
// axis_frame_tx : burst-of-frames AXI-Stream source with incrementing payload
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_frame_tx
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int LEN_WIDTH  = AXIS_LEN_WIDTH,
    parameter int CNT_WIDTH  = AXIS_CNT_WIDTH
) (
    input  logic                  s_axis_clk,
    input  logic                  s_axis_resetn,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [CNT_WIDTH-1:0]  frames_i,
    input  logic [CNT_WIDTH-1:0]  gap_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  m_axis_tready
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    logic [TX_STATE_WIDTH-1:0] state;
    logic [TX_STATE_WIDTH-1:0] next_state;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  frames_q;
    logic [CNT_WIDTH-1:0]  gap_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [CNT_WIDTH-1:0]  gap_cnt;
    logic [CNT_WIDTH-1:0]  frame_cnt;
    logic [DATA_WIDTH-1:0] data_q;

    logic accept;
    logic beat_last;
    logic xfer;
    logic last_frame;

    assign accept     = (state == ST_IDLE) && start_i &&
                        (len_i != '0) && (frames_i != '0);
    assign beat_last  = (beat_cnt == len_q);
    assign xfer       = (state == ST_SEND) && m_axis_tready;
    // frame_cnt counts completed frames, so the final frame is in flight
    // once frames_q-1 have completed; no wider counter is needed.
    assign last_frame = (frame_cnt == (frames_q - CNT_ONE));

    always_ff @(posedge s_axis_clk) begin
        if (!s_axis_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer && beat_last) begin
                    if (last_frame) begin
                        next_state = ST_FIN;
                    end else if (gap_q != CNT_ZERO) begin
                        next_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == CNT_ONE) begin
                    next_state = ST_SEND;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m_axis_tvalid = (state == ST_SEND);
        m_axis_tlast  = (state == ST_SEND) && beat_last;
        busy_o        = (state == ST_SEND) || (state == ST_GAP);
        done_o        = (state == ST_FIN);
    end

    assign m_axis_tdata = data_q;
    assign frame_cnt_o  = frame_cnt;

    always_ff @(posedge s_axis_clk) begin
        if (!s_axis_resetn) begin
            len_q     <= '0;
            frames_q  <= '0;
            gap_q     <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            data_q    <= '0;
        end else begin
            if (accept) begin
                len_q     <= len_i;
                frames_q  <= frames_i;
                gap_q     <= gap_i;
                data_q    <= seed_i;
                beat_cnt  <= LEN_ONE;
                frame_cnt <= '0;
            end
            if (xfer) begin
                data_q <= data_q + DATA_ONE;
                if (beat_last) begin
                    beat_cnt  <= LEN_ONE;
                    frame_cnt <= frame_cnt + CNT_ONE;
                    gap_cnt   <= gap_q;
                end else begin
                    beat_cnt <= beat_cnt + LEN_ONE;
                end
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - CNT_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_tx.sv
//------------------------------------------------------------------------------
// tb_axis_frame_tx : table-driven and randomized burst checks for axis_frame_tx
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_frame_tx;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [15:0] len;
    logic [7:0]  frames;
    logic [7:0]  gap;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic [7:0]  frame_cnt;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        tready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_frame_tx dut (
        .s_axis_clk    (clk),
        .s_axis_resetn (resetn),
        .start_i       (start),
        .len_i         (len),
        .frames_i      (frames),
        .gap_i         (gap),
        .seed_i        (seed),
        .busy_o        (busy),
        .done_o        (done),
        .frame_cnt_o   (frame_cnt),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tdata  (tdata),
        .m_axis_tready (tready)
    );

    // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready
    typedef struct {
        logic [31:0] seed;
        int          len;
        int          frames;
        int          gap;
        int          mode;
        bit          mid_start;
        logic [31:0] exp_last;
        int          exp_frames;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        logic [31:0] exp_d[$];
        bit          exp_l[$];
        int          total;
        int          idx  = 0;
        int          idle = 0;
        int          cyc  = 0;
        bit          hold = 0;
        bit          r;
        logic [31:0] last_xfer = '0;

        total = v.len * v.frames;
        for (int k = 0; k < total; k++) begin
            exp_d.push_back(v.seed + 32'(k));
            exp_l.push_back((k % v.len) == (v.len - 1));
        end

        @(negedge clk);
        start  = 1'b1;
        len    = 16'(v.len);
        frames = 8'(v.frames);
        gap    = 8'(v.gap);
        seed   = v.seed;
        @(negedge clk);
        start  = 1'b0;
        len    = 16'($urandom);
        frames = 8'($urandom);
        gap    = 8'($urandom);
        seed   = $urandom;
        chk("first_valid", 64'(tvalid), 64'd1);
        chk("first_data", 64'(tdata), 64'(v.seed));

        while (idx < total && cyc < 4000) begin
            chk("busy", 64'(busy), 64'd1);
            chk("done_early", 64'(done), 64'd0);
            chk("frame_cnt", 64'(frame_cnt), 64'(idx / v.len));
            if (hold) chk("hold_valid", 64'(tvalid), 64'd1);
            if (tvalid) begin
                if (!hold && idx > 0 && (idx % v.len) == 0)
                    chk("gap_len", 64'(idle), 64'(v.gap));
                idle = 0;
                chk("tdata", 64'(tdata), 64'(exp_d[idx]));
                chk("tlast", 64'(tlast), 64'(exp_l[idx]));
            end else begin
                idle++;
                if (idx == 0 || (idx % v.len) != 0)
                    chk("midframe_idle", 64'(tvalid), 64'd1);
            end

            case (v.mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            if (v.mid_start && cyc == 2) begin
                start  = 1'b1;
                len    = 16'd3;
                frames = 8'd1;
                seed   = 32'hDEAD_0000;
            end else begin
                start = 1'b0;
            end
            tready = r;
            hold   = tvalid && !r;
            if (tvalid && r) begin
                last_xfer = tdata;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;

        if (idx < total) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", idx, total);
        end else begin
            chk("done_pulse", 64'(done), 64'd1);
            chk("fin_busy", 64'(busy), 64'd0);
            chk("fin_valid", 64'(tvalid), 64'd0);
            chk("fin_frames", 64'(frame_cnt), 64'(v.exp_frames));
            chk("last_beat", 64'(last_xfer), 64'(v.exp_last));
            @(negedge clk);
            chk("done_once", 64'(done), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("frames_hold", 64'(frame_cnt), 64'(v.exp_frames));
        end
    endtask

    task automatic idle_checks(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_busy"}, 64'(busy), 64'd0);
            chk({tag, "_valid"}, 64'(tvalid), 64'd0);
            chk({tag, "_done"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t rv;

        tbl[0] = '{32'h10, 4, 1, 0, 0, 1'b0, 32'h13, 1};
        tbl[1] = '{32'h10, 4, 1, 0, 1, 1'b0, 32'h13, 1};
        tbl[2] = '{32'hFFFF_FFFE, 3, 2, 2, 0, 1'b0, 32'h3, 2};
        tbl[3] = '{32'h100, 1, 3, 0, 0, 1'b0, 32'h102, 3};
        tbl[4] = '{32'h55, 5, 2, 1, 2, 1'b1, 32'h5E, 2};
        tbl[5] = '{32'h7, 2, 3, 3, 1, 1'b0, 32'hC, 3};

        resetn = 1'b0;
        start  = 1'b0;
        len    = '0;
        frames = '0;
        gap    = '0;
        seed   = '0;
        tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_frames", 64'(frame_cnt), 64'd0);
        chk("rst_data", 64'(tdata), 64'd0);
        chk("rst_last", 64'(tlast), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tready = 1'b1;
            run_burst(tbl[i]);
        end

        // zero-length and zero-frame starts must be ignored
        @(negedge clk);
        start = 1'b1; len = 16'd0; frames = 8'd2; seed = 32'h1234;
        idle_checks("len0", 3);
        @(negedge clk);
        start = 1'b1; len = 16'd4; frames = 8'd0;
        idle_checks("frames0", 3);

        // reset while the second beat of a len=8 burst is presented
        @(negedge clk);
        start = 1'b1; len = 16'd8; frames = 8'd1; gap = 8'd0; seed = 32'hA0;
        tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_mid_b1", 64'(tdata), 64'hA0);
        @(negedge clk);
        chk("rst_mid_b2", 64'(tdata), 64'hA1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_valid", 64'(tvalid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_frames", 64'(frame_cnt), 64'd0);
        idle_checks("post_abort", 2);
        rv = '{32'hA0, 8, 1, 0, 0, 1'b0, 32'hA7, 1};
        run_burst(rv);

        for (int i = 0; i < 8; i++) begin
            rv.seed      = $urandom;
            rv.len       = int'($urandom_range(1, 6));
            rv.frames    = int'($urandom_range(1, 4));
            rv.gap       = int'($urandom_range(0, 3));
            rv.mode      = int'($urandom_range(0, 2));
            rv.mid_start = ($urandom_range(0, 1) == 1);
            rv.exp_last  = rv.seed + 32'(rv.len * rv.frames) - 32'd1;
            rv.exp_frames = rv.frames;
            tready = 1'b1;
            run_burst(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
